// File: rtl/atuador_pkg.sv
// Shared state encodings and default timing constants for the actuator controller.
package atuador_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ON    = 2'b01,
        ST_COOL  = 2'b10,
        ST_FAULT = 2'b11
    } estado_t;

    localparam int unsigned DEF_DEB_CYCLES = 4;
    localparam int unsigned DEF_MIN_ON     = 8;
    localparam int unsigned DEF_MIN_OFF    = 8;
    localparam int unsigned DEF_MAX_ON     = 64;
    localparam int unsigned DEF_CNT_W      = 8;

endpackage

// File: rtl/filtro_debounce.sv
// Two-flop synchroniser followed by a stability filter: q_out only follows the
// synchronised input after DEB_CYCLES consecutive mismatching cycles.
module filtro_debounce
    import atuador_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= d_in;
            r_sync2 <= r_sync1;
            // Any cycle of agreement restarts the stability window.
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign q_out = r_filt;

endmodule

// File: rtl/controlador_de_atuador.sv
// Actuator drive controller: debounced request, minimum on/off times and a
// maximum on-time watchdog that latches a fault until acknowledged.
module controlador_de_atuador
    import atuador_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int unsigned MIN_ON     = DEF_MIN_ON,
    parameter int unsigned MIN_OFF    = DEF_MIN_OFF,
    parameter int unsigned MAX_ON     = DEF_MAX_ON,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel_in,
    input  logic       fault_clr,
    output logic       act_out,
    output logic       fault,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MIN_OFF_LAST = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] MAX_ON_LAST  = CNT_W'(MAX_ON - 1);

    logic             w_req_f;
    estado_t          r_state;
    estado_t          w_next;
    logic [CNT_W-1:0] r_timer;
    logic             r_act;
    logic             r_fault;

    filtro_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_filtro (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (sel_in),
        .q_out(w_req_f)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OFF: begin
                if (w_req_f) w_next = ST_ON;
            end
            ST_ON: begin
                // Watchdog is checked first so it wins over a simultaneous release.
                if (w_req_f && (r_timer == MAX_ON_LAST)) begin
                    w_next = ST_FAULT;
                end else if (!w_req_f && (r_timer >= MIN_ON_LAST)) begin
                    w_next = ST_COOL;
                end
            end
            ST_COOL: begin
                if (r_timer == MIN_OFF_LAST) w_next = ST_OFF;
            end
            ST_FAULT: begin
                if (fault_clr && !w_req_f) w_next = ST_COOL;
            end
            default: w_next = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
            r_timer <= '0;
            r_act   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_act   <= (w_next == ST_ON);
            r_fault <= (w_next == ST_FAULT);
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign act_out = r_act;
    assign fault   = r_fault;
    assign state   = r_state;

endmodule

// File: tb/tb_controlador_de_atuador.sv
// Scoreboard bench: stimulus queues the expected output transitions with the
// cycle they must occur on; a monitor pops one per observed output change.
module tb_controlador_de_atuador;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  st;
        logic        act;
        logic        flt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       sel_in;
    logic       fault_clr;
    logic       act_out;
    logic       fault;
    logic [1:0] state;

    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          mon_en = 0;
    logic [3:0]  prev   = '0;
    exp_t        q[$];

    controlador_de_atuador #(
        .DEB_CYCLES(4),
        .MIN_ON    (8),
        .MIN_OFF   (8),
        .MAX_ON    (64),
        .CNT_W     (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_in   (sel_in),
        .fault_clr(fault_clr),
        .act_out  (act_out),
        .fault    (fault),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of {state, act_out, fault} must match the queue head.
    always @(negedge clk) begin
        logic [3:0] cur;
        exp_t       e;
        cur = {state, act_out, fault};
        if (mon_en && (cur !== prev)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got st=%b act=%b flt=%b required no change",
                         cyc, state, act_out, fault);
            end else begin
                e = q.pop_front();
                if ((e.cyc != cyc) || (cur !== {e.st, e.act, e.flt})) begin
                    errors++;
                    $display("FAIL event cyc=%0d st=%b act=%b flt=%b required cyc=%0d st=%b act=%b flt=%b",
                             cyc, state, act_out, fault, e.cyc, e.st, e.act, e.flt);
                end
            end
        end
        prev = cur;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int unsigned c, input logic [1:0] st, input logic a, input logic f);
        exp_t e;
        e.cyc = c;
        e.st  = st;
        e.act = a;
        e.flt = f;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %b required %b", name, got, req);
        end
    endtask

    task automatic chk_drained(input string name);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s pending events got %0d required 0 (next cyc=%0d)",
                     name, q.size(), q[0].cyc);
            q.delete();
        end
    endtask

    initial begin
        int unsigned t0;
        int unsigned t1;
        rst_n     = 1'b0;
        sel_in    = 1'b1;
        fault_clr = 1'b0;

        // Reset held with request high: everything stays cleared.
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk($sformatf("reset_hold_%0d", i), {state, act_out, fault}, 4'b0000);
        end
        sel_in = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        mon_en = 1;

        // Short glitch is filtered out.
        t0 = cyc;
        sel_in = 1'b1;
        tick(3);
        sel_in = 1'b0;
        tick(20);
        chk("glitch_state", {state, act_out, fault}, 4'b0000);
        chk_drained("glitch");

        // Long request: rise on edge 7, fall 7 edges after release, 8 cycles of cooldown.
        t0 = cyc;
        sel_in = 1'b1;
        expect_ev(t0 + 7, 2'b01, 1'b1, 1'b0);
        tick(20);
        t1 = cyc;
        sel_in = 1'b0;
        expect_ev(t1 + 7, 2'b10, 1'b0, 1'b0);
        expect_ev(t1 + 15, 2'b00, 1'b0, 1'b0);
        tick(20);
        chk_drained("long_request");

        // Early release is stretched to the minimum on-time.
        t0 = cyc;
        sel_in = 1'b1;
        expect_ev(t0 + 7, 2'b01, 1'b1, 1'b0);
        expect_ev(t0 + 15, 2'b10, 1'b0, 1'b0);
        expect_ev(t0 + 23, 2'b00, 1'b0, 1'b0);
        tick(5);
        sel_in = 1'b0;
        tick(25);
        chk_drained("min_on");

        // Watchdog: 64 on-cycles then fault; acknowledge ignored while request high.
        t0 = cyc;
        sel_in = 1'b1;
        expect_ev(t0 + 7, 2'b01, 1'b1, 1'b0);
        expect_ev(t0 + 71, 2'b11, 1'b0, 1'b1);
        expect_ev(t0 + 116, 2'b10, 1'b0, 1'b0);
        expect_ev(t0 + 124, 2'b00, 1'b0, 1'b0);
        tick(80);
        fault_clr = 1'b1;
        tick(5);
        fault_clr = 1'b0;
        chk("fault_clr_ignored", {state, act_out, fault}, 4'b1101);
        tick(15);
        sel_in = 1'b0;
        tick(15);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        tick(14);
        chk_drained("watchdog");

        // Asynchronous reset mid-ON drops the actuator before the next edge.
        t0 = cyc;
        sel_in = 1'b1;
        expect_ev(t0 + 7, 2'b01, 1'b1, 1'b0);
        tick(10);
        chk("pre_reset_on", {state, act_out, fault}, 4'b0110);
        chk_drained("pre_reset");
        #2;
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        chk("async_reset", {state, act_out, fault}, 4'b0000);
        tick(2);
        rst_n = 1'b1;
        t0 = cyc;
        mon_en = 1;
        expect_ev(t0 + 7, 2'b01, 1'b1, 1'b0);
        tick(10);
        t1 = cyc;
        sel_in = 1'b0;
        expect_ev(t1 + 7, 2'b10, 1'b0, 1'b0);
        expect_ev(t1 + 15, 2'b00, 1'b0, 1'b0);
        tick(20);
        chk_drained("post_reset");

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
